// File: rtl/regfile_pkg.sv
// Shared register-file geometry and write-port source encoding for the WB/MC arbiter.
package regfile_pkg;
   localparam int unsigned NREGS = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 32;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_WB,
      SRC_MC
   } port_src_e;
endpackage

// File: rtl/wb_result_fifo.sv
// Holding queue for multi-cycle results waiting for a free register-file write slot.
module wb_result_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 32
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic [AW-1:0] push_rd_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   output logic [AW-1:0] head_rd_o,
   output logic [DW-1:0] head_data_o,
   output logic          full_o,
   output logic          empty_o
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [AW-1:0] rd_mem_q   [DEPTH];
   logic [DW-1:0] data_mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok, pop_ok;

   assign full_o      = (count_q == CW'(DEPTH));
   assign empty_o     = (count_q == '0);
   assign head_rd_o   = rd_mem_q[rd_ptr_q];
   assign head_data_o = data_mem_q[rd_ptr_q];
   assign push_ok     = push_i && !full_o;
   assign pop_ok      = pop_i && !empty_o;

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         rd_mem_q[wr_ptr_q]   <= push_rd_i;
         data_mem_q[wr_ptr_q] <= push_data_i;
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the WB stage and the multi-cycle unit,
// tracks MC destinations in a busy scoreboard and raises the ID hazard/starvation stall.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned QDEPTH     = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wb_we,
   input  logic [AW-1:0]    wb_rd,
   input  logic [DW-1:0]    wb_data,
   input  logic             mc_issue,
   input  logic [AW-1:0]    mc_issue_rd,
   input  logic             mc_valid,
   input  logic [AW-1:0]    mc_rd,
   input  logic [DW-1:0]    mc_data,
   output logic             mc_ready,
   input  logic             id_valid,
   input  logic [AW-1:0]    id_rs1,
   input  logic [AW-1:0]    id_rs2,
   input  logic [AW-1:0]    id_rd,
   output logic             stall,
   output logic             WE_reg,
   output logic [AW-1:0]    A3,
   output logic [DW-1:0]    WD_reg,
   output logic [NREGS-1:0] busy_vec
);
   localparam int unsigned SW = $clog2(STARVE_MAX + 1);

   logic [NREGS-1:0] busy_q, busy_d;
   logic [SW-1:0]    starve_q, starve_d;
   port_src_e        src;
   logic             wb_hit, push, pop;
   logic             fifo_full, fifo_empty;
   logic [AW-1:0]    head_rd;
   logic [DW-1:0]    head_data;
   logic             hazard, starve_force;

   wb_result_fifo #(
      .DEPTH (QDEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fifo (
      .clk_i       (clk),
      .rst_ni      (rst),
      .push_i      (push),
      .push_rd_i   (mc_rd),
      .push_data_i (mc_data),
      .pop_i       (pop),
      .head_rd_o   (head_rd),
      .head_data_o (head_data),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign wb_hit = wb_we && (wb_rd != '0);
   assign push   = mc_valid && !fifo_full && (mc_rd != '0);
   assign pop    = (src == SRC_MC);

   // rst only gates outputs here; state is already held by the async reset.
   always_comb begin
      src    = SRC_NONE;
      WE_reg = 1'b0;
      A3     = '0;
      WD_reg = '0;
      if (wb_hit)           src = SRC_WB;
      else if (!fifo_empty) src = SRC_MC;
      if (rst) begin
         case (src)
            SRC_WB: begin
               WE_reg = 1'b1;
               A3     = wb_rd;
               WD_reg = wb_data;
            end
            SRC_MC: begin
               WE_reg = 1'b1;
               A3     = head_rd;
               WD_reg = head_data;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy_d = busy_q;
      if (pop) busy_d[head_rd] = 1'b0;
      if (mc_issue && (mc_issue_rd != '0)) busy_d[mc_issue_rd] = 1'b1;
      busy_d[0] = 1'b0;

      starve_d = starve_q;
      if (pop) starve_d = '0;
      else if (!fifo_empty && wb_hit && (starve_q != SW'(STARVE_MAX)))
         starve_d = starve_q + SW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q   <= '0;
         starve_q <= '0;
      end else begin
         busy_q   <= busy_d;
         starve_q <= starve_d;
      end
   end

   // Registered busy bits: a clear landing this edge still stalls this cycle's ID read.
   assign hazard       = id_valid && (busy_q[id_rs1] || busy_q[id_rs2] || busy_q[id_rd]);
   assign starve_force = (starve_q == SW'(STARVE_MAX));
   assign stall        = rst && (hazard || starve_force);
   assign mc_ready     = rst && !fifo_full;
   assign busy_vec     = busy_q;
endmodule
